seq_muldiv: RTL and testbench
=============================

# seq_muldiv

Parametrised iterative multiply/divide unit for the microC ALU datapath. It extends the existing single-cycle adders, negators and shifters with multi-cycle operations: signed and unsigned WIDTH×WIDTH→2·WIDTH multiply, and signed and unsigned WIDTH/WIDTH divide with remainder. It sits beside the combinational ALU and is driven by the control unit through a start/busy/done handshake.

## Interface
- WIDTH, 32: operand width in bits, any even value ≥ 4.
- clk  in  1  rising-edge clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- start  in  1  request strobe, sampled on the rising edge of clk.
- op  in  2  operation: 00 MULU, 01 MUL (signed), 10 DIVU, 11 DIV (signed). Captured with start.
- a  in  WIDTH  multiplicand or dividend, captured with start.
- b  in  WIDTH  multiplier or divisor, captured with start.
- busy  out  1  high while a request is in progress.
- done  out  1  one-cycle pulse; the results are valid in that cycle.
- result_lo  out  WIDTH  product[WIDTH-1:0] or quotient.
- result_hi  out  WIDTH  product[2·WIDTH-1:WIDTH] or remainder.
- div_by_zero  out  1  set with done when a divide has b==0; otherwise low with done.

## Operation
- States:
  - IDLE
  - CALC: WIDTH iterations, counter counts 0..WIDTH-1.
  - FIX: sign correction and output register load.
  - DONE: done=1 for one cycle.
- Transitions:
  - IDLE→CALC when start=1.
  - CALC→FIX after iteration WIDTH-1.
  - FIX→DONE unconditionally.
  - DONE→CALC if start=1 in the DONE cycle (back-to-back requests); otherwise DONE→IDLE.
- start is ignored in CALC and FIX. It causes no error and does not alter the captured operands.
- Signed ops convert both operands to magnitudes at capture. The core works unsigned.
- Multiply is shift-add, one multiplier bit per iteration, with a (WIDTH+1)-bit accumulator add. In FIX, the 2·WIDTH product is negated if the operand signs differ.
- Divide is restoring, one quotient bit per iteration, with a (WIDTH+1)-bit trial subtract.
  - Signed quotient truncates toward zero; the remainder takes the sign of the dividend.
  - The quotient is negated if the signs differ; the remainder is negated if a was negative.
- Divide by zero (b==0): quotient all ones, remainder = original a, div_by_zero=1. No sign fix is applied, for both DIV and DIVU.
- Signed overflow (a = most-negative, b = −1): quotient = most-negative, remainder = 0, div_by_zero=0. This falls out of the magnitude algorithm; no special case.
- result_lo, result_hi and div_by_zero are separate registers. They load only in FIX and hold their values until the next FIX.

## Timing
- Start sampled in cycle 0 → CALC in cycles 1..WIDTH → FIX in cycle WIDTH+1 → DONE in cycle WIDTH+2. With WIDTH=32, done occurs in cycle 34.
- Latency is fixed and independent of the operand values or op.
- busy=1 in CALC and FIX. busy=0 in IDLE and DONE.
- Back-to-back: a start in the DONE cycle counts as cycle 0 of the next request.
- Reset value of every output is 0: busy, done, result_lo, result_hi, div_by_zero. State returns to IDLE and the counter to 0.
- Reset asserted mid-operation:
  - the request is abandoned;
  - all outputs are 0 in the cycle after the reset edge;
  - no done is produced for that request.
- If rst and start are high on the same edge, rst wins and the request is dropped.

## Structure
- Shared package alu_pkg holds:
  - the op encodings OP_MULU, OP_MUL, OP_DIVU, OP_DIV;
  - the state enum IDLE/CALC/FIX/DONE.
- One sub-module, addsub_w: a parametrised WIDTH+1 adder/subtractor with a sub control and carry-out. The iteration step uses it for both the multiply accumulate and the divide trial subtract.
- Sign correction uses two's-complement negation (invert + 1), consistent with the existing negate block, applied to the 2·WIDTH product or to the WIDTH-bit quotient/remainder.

## Test plan
All cases use WIDTH=32.
- MULU a=0xFFFFFFFF, b=0xFFFFFFFF → done in cycle 34, result_hi=0xFFFFFFFE, result_lo=0x00000001.
- MUL a=0xFFFFFFFD (−3), b=7 → result_hi=0xFFFFFFFF, result_lo=0xFFFFFFEB (−21).
- DIV a=0xFFFFFFF9 (−7), b=2 → result_lo=0xFFFFFFFD (−3), result_hi=0xFFFFFFFF (−1), div_by_zero=0.
- DIVU a=0x64, b=0 → result_lo=0xFFFFFFFF, result_hi=0x64, div_by_zero=1. Then DIV a=0x80000000, b=0xFFFFFFFF → result_lo=0x80000000, result_hi=0, div_by_zero=0.
- Handshake and reset:
  - Pulse start at cycle 5 of a running MULU 6×7: ignored; the request completes with 42.
  - A start in the DONE cycle produces the next done exactly 34 cycles later.
  - rst at cycle 10 of a request: busy=0 and results=0 next cycle, and no done is ever produced.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiply/divide op encodings and the iterative unit's state enum.
package alu_pkg;

  localparam logic [1:0] OP_MULU = 2'b00;
  localparam logic [1:0] OP_MUL  = 2'b01;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_DIV  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/addsub_w.sv
// Parametrised adder/subtractor with carry-out; sub=1 computes a - b as a + ~b + 1.
module addsub_w #(
  parameter int DATA_W = 33
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  logic [DATA_W-1:0] w_b_eff;

  assign w_b_eff = b ^ {DATA_W{sub}};
  // For subtraction, cout=1 means a >= b (no borrow).
  assign {cout, sum} = {1'b0, a} + {1'b0, w_b_eff} + {{DATA_W{1'b0}}, sub};

endmodule

// File: rtl/seq_muldiv.sv
// Iterative WIDTHxWIDTH multiply (shift-add) and WIDTH/WIDTH divide (restoring), signed
// and unsigned, with a start/busy/done handshake and fixed WIDTH+2 cycle latency.
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_dw(input logic [2*WIDTH-1:0] x);
    return ~x + (2*WIDTH)'(1);
  endfunction

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_op;
  logic             r_neg_a, r_neg_b, r_bzero;
  logic [WIDTH-1:0] r_a_orig;
  logic [WIDTH-1:0] r_acc;   // product high half / partial remainder
  logic [WIDTH-1:0] r_q;     // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] r_m;     // multiplicand or divisor magnitude

  logic             w_capture, w_sgn, w_is_div, w_cap_div;
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  logic [WIDTH:0]   w_as_a, w_as_b, w_sum;
  logic             w_as_sub, w_cout;
  logic [WIDTH-1:0] w_acc_nxt, w_q_nxt;
  logic [2*WIDTH-1:0] w_prod;

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      IDLE: if (start) w_state_nxt = CALC;
      CALC: begin
        busy = 1'b1;
        if (r_cnt == CNT_LAST) w_state_nxt = FIX;
      end
      FIX: begin
        busy        = 1'b1;
        w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = start ? CALC : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_capture = start && !rst && (r_state == IDLE || r_state == DONE);
  assign w_sgn     = (op == OP_MUL) || (op == OP_DIV);
  assign w_cap_div = (op == OP_DIVU) || (op == OP_DIV);
  assign w_is_div  = (r_op == OP_DIVU) || (r_op == OP_DIV);
  assign w_mag_a   = (w_sgn && a[WIDTH-1]) ? neg_w(a) : a;
  assign w_mag_b   = (w_sgn && b[WIDTH-1]) ? neg_w(b) : b;

  // Iteration step: accumulate for multiply, trial subtract of the shifted remainder for divide.
  always_comb begin
    if (w_is_div) begin
      w_as_a   = {r_acc, r_q[WIDTH-1]};
      w_as_b   = {1'b0, r_m};
      w_as_sub = 1'b1;
    end else begin
      w_as_a   = {1'b0, r_acc};
      w_as_b   = r_q[0] ? {1'b0, r_m} : '0;
      w_as_sub = 1'b0;
    end
  end

  addsub_w #(.DATA_W(WIDTH + 1)) u_addsub (
    .a    (w_as_a),
    .b    (w_as_b),
    .sub  (w_as_sub),
    .sum  (w_sum),
    .cout (w_cout)
  );

  always_comb begin
    if (w_is_div) begin
      if (w_cout) begin
        w_acc_nxt = w_sum[WIDTH-1:0];
        w_q_nxt   = {r_q[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nxt = {r_acc[WIDTH-2:0], r_q[WIDTH-1]};
        w_q_nxt   = {r_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_acc_nxt = w_sum[WIDTH:1];
      w_q_nxt   = {w_sum[0], r_q[WIDTH-1:1]};
    end
  end

  assign w_prod = (r_neg_a ^ r_neg_b) ? neg_dw({r_acc, r_q}) : {r_acc, r_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      result_lo   <= '0;
      result_hi   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) begin
        r_cnt <= '0;
      end else if (r_state == CALC) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (r_state == FIX) begin
        if (!w_is_div) begin
          {result_hi, result_lo} <= w_prod;
          div_by_zero            <= 1'b0;
        end else if (r_bzero) begin
          result_lo   <= '1;
          result_hi   <= r_a_orig;
          div_by_zero <= 1'b1;
        end else begin
          result_lo   <= (r_neg_a ^ r_neg_b) ? neg_w(r_q) : r_q;
          result_hi   <= r_neg_a ? neg_w(r_acc) : r_acc;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

  // Operand datapath: loaded at capture, stepped during CALC; no reset needed.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_op     <= op;
      r_neg_a  <= w_sgn & a[WIDTH-1];
      r_neg_b  <= w_sgn & b[WIDTH-1];
      r_a_orig <= a;
      r_bzero  <= (b == '0);
      r_acc    <= '0;
      r_m      <= w_cap_div ? w_mag_b : w_mag_a;
      r_q      <= w_cap_div ? w_mag_a : w_mag_b;
    end else if (r_state == CALC) begin
      r_acc <= w_acc_nxt;
      r_q   <= w_q_nxt;
    end
  end

endmodule

// File: tb/tb_seq_muldiv.sv
// Scoreboard bench for seq_muldiv (WIDTH=32): expected results queued at issue, popped at done.
module tb_seq_muldiv;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  a = '0, b = '0;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  result_lo, result_hi;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  seq_muldiv #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t   e;
    longint p;
    int     sx, sy;
    e.dbz = 1'b0;
    case (o)
      2'b00: begin p = longint'({32'b0, x}) * longint'({32'b0, y}); {e.hi, e.lo} = p; end
      2'b01: begin p = longint'($signed(x)) * longint'($signed(y)); {e.hi, e.lo} = p; end
      default: begin
        if (y == 0) begin
          e.lo = '1; e.hi = x; e.dbz = 1'b1;
        end else if (o == 2'b10) begin
          e.lo = x / y; e.hi = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000; e.hi = '0;
        end else begin
          sx = x; sy = y;
          e.lo = sx / sy; e.hi = sx % sy;
        end
      end
    endcase
    return e;
  endfunction

  // Drive one start strobe; returns positioned in cycle 1 of the request.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for done; lat is the cycle number (start cycle = 0) in which done is seen, -1 on timeout.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (lat <= 200) begin
      @(negedge clk);
      if (done === 1'b1) return;
      @(posedge clk);
      lat++;
    end
    lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, div_by_zero, result_lo, result_hi} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b lo=%h hi=%h, want all 0",
               busy, done, div_by_zero, result_lo, result_hi);
    end
  endtask

  task automatic test_vectors();
    logic [1:0]   vo[13];
    logic [W-1:0] va[13], vb[13];
    exp_t         e, got;
    int           lat;
    vo[0] = 2'b00; va[0] = 32'hFFFF_FFFF; vb[0] = 32'hFFFF_FFFF;
    vo[1] = 2'b01; va[1] = 32'hFFFF_FFFD; vb[1] = 32'd7;
    vo[2] = 2'b11; va[2] = 32'hFFFF_FFF9; vb[2] = 32'd2;
    vo[3] = 2'b10; va[3] = 32'h64;        vb[3] = 32'd0;
    vo[4] = 2'b11; va[4] = 32'h8000_0000; vb[4] = 32'hFFFF_FFFF;
    for (int i = 5; i < 13; i++) begin
      vo[i] = 2'($urandom_range(0, 3));
      va[i] = $urandom;
      vb[i] = (i == 9) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
      if (i == 9) vo[i] = 2'b11;
    end
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      case (i)
        0: begin e.lo = 32'h0000_0001; e.hi = 32'hFFFF_FFFE; e.dbz = 1'b0; end
        1: begin e.lo = 32'hFFFF_FFEB; e.hi = 32'hFFFF_FFFF; e.dbz = 1'b0; end
        2: begin e.lo = 32'hFFFF_FFFD; e.hi = 32'hFFFF_FFFF; e.dbz = 1'b0; end
        3: begin e.lo = 32'hFFFF_FFFF; e.hi = 32'h0000_0064; e.dbz = 1'b1; end
        4: begin e.lo = 32'h8000_0000; e.hi = 32'h0000_0000; e.dbz = 1'b0; end
        default: e = model(vo[i], va[i], vb[i]);
      endcase
      sb.push_back(e);
      issue(vo[i], va[i], vb[i]);
      wait_done(1, lat);
      n_cmp++;
      if (lat != 34) begin
        n_err++;
        $display("FAIL vec%0d_latency: got %0d, want 34", i, lat);
      end
      e = sb.pop_front();
      got.lo = result_lo; got.hi = result_hi; got.dbz = div_by_zero;
      n_cmp++;
      if ({got.hi, got.lo, got.dbz} !== {e.hi, e.lo, e.dbz}) begin
        n_err++;
        $display("FAIL vec%0d_result op=%0d a=%h b=%h: got hi=%h lo=%h dbz=%b, want hi=%h lo=%h dbz=%b",
                 i, vo[i], va[i], vb[i], got.hi, got.lo, got.dbz, e.hi, e.lo, e.dbz);
      end
    end
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int   lat;
    @(posedge clk); #1;
    e.lo = 32'd42; e.hi = '0; e.dbz = 1'b0;
    sb.push_back(e);
    issue(2'b00, 32'd6, 32'd7);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL ignore_busy: got %b, want 1", busy);
    end
    wait_done(6, lat);
    n_cmp++;
    if (lat != 34) begin
      n_err++;
      $display("FAIL ignore_latency: got %0d, want 34", lat);
    end
    e = sb.pop_front();
    n_cmp++;
    if ({result_hi, result_lo, div_by_zero} !== {e.hi, e.lo, e.dbz}) begin
      n_err++;
      $display("FAIL ignore_result: got hi=%h lo=%h dbz=%b, want hi=%h lo=%h dbz=%b",
               result_hi, result_lo, div_by_zero, e.hi, e.lo, e.dbz);
    end
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++;
      $display("FAIL ignore_no_second: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    @(posedge clk); #1;
    sb.push_back(model(2'b01, 32'hFFFF_FFFD, 32'd7));
    issue(2'b01, 32'hFFFF_FFFD, 32'd7);
    wait_done(1, lat);
    e = sb.pop_front();
    n_cmp++;
    if ({lat == 34, busy, result_hi, result_lo} !== {1'b1, 1'b0, e.hi, e.lo}) begin
      n_err++;
      $display("FAIL b2b_first: got lat=%0d busy=%b hi=%h lo=%h, want lat=34 busy=0 hi=%h lo=%h",
               lat, busy, result_hi, result_lo, e.hi, e.lo);
    end
    e.lo = 32'd142; e.hi = 32'd6; e.dbz = 1'b0;
    sb.push_back(e);
    start = 1'b1; op = 2'b10; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1, lat);
    n_cmp++;
    if (lat != 34) begin
      n_err++;
      $display("FAIL b2b_latency: got %0d, want 34", lat);
    end
    e = sb.pop_front();
    n_cmp++;
    if ({result_hi, result_lo, div_by_zero} !== {e.hi, e.lo, e.dbz}) begin
      n_err++;
      $display("FAIL b2b_second: got hi=%h lo=%h dbz=%b, want hi=%h lo=%h dbz=%b",
               result_hi, result_lo, div_by_zero, e.hi, e.lo, e.dbz);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(posedge clk); #1;
    issue(2'b00, 32'd3, 32'd5);
    repeat (8) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done, div_by_zero, result_lo, result_hi} !== '0) begin
      n_err++;
      $display("FAIL rstmid_outputs: got busy=%b done=%b dbz=%b lo=%h hi=%h, want all 0",
               busy, done, div_by_zero, result_lo, result_hi);
    end
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (done !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL rstmid_no_done: got %0d done cycles, want 0", seen);
    end
  endtask

  task automatic test_reset_start_same();
    int seen;
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL rststart_busy: got %b, want 0", busy);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL rststart_idle: got %0d active cycles, want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_reset_start_same();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
